// File: rtl/mem_store_buffer_pkg.sv
// mem_pkg: shared types and constants for the store buffer and its forwarding merge.
package mem_pkg;

  // Word-address field wide enough for any supported ADDR_W (ADDR_W - 2 <= 62).
  localparam int SB_WADDR_W = 62;

  // Byte-lane masks for the 4-byte write select.
  localparam logic [3:0] SB_BYTE0     = 4'b0001;
  localparam logic [3:0] SB_BYTE1     = 4'b0010;
  localparam logic [3:0] SB_BYTE2     = 4'b0100;
  localparam logic [3:0] SB_BYTE3     = 4'b1000;
  localparam logic [3:0] SB_WSEL_NONE = 4'b0000;
  localparam logic [3:0] SB_WSEL_ALL  = 4'b1111;

  typedef struct packed {
    logic [SB_WADDR_W-1:0] waddr;
    logic [31:0]           data;
    logic [3:0]            wsel;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Drain bus from the store buffer to the data SRAM.
interface mem_store_buffer_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wsel;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, output mem_wdata, output mem_wsel,
                  input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, input mem_wsel,
                  output mem_ack);
endinterface

// File: rtl/mem_store_buffer_fwd.sv
// sb_fwd_merge: per-byte youngest-match selection for load forwarding.
// Entries arrive ordered oldest (index 0) to youngest; a later match overrides an earlier one.
module sb_fwd_merge
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t [DEPTH-1:0] ent_i,
  input  logic [DEPTH-1:0]      vld_i,
  input  logic                  ld_valid,
  input  logic [SB_WADDR_W-1:0] ld_waddr,
  output logic [31:0]           fwd_data,
  output logic [3:0]            fwd_mask
);

  // Walk entries oldest to youngest so the youngest writer of each byte wins.
  always_comb begin
    fwd_data = '0;
    fwd_mask = SB_WSEL_NONE;
    if (ld_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (vld_i[k] && (ent_i[k].waddr == ld_waddr)) begin
          for (int b = 0; b < 4; b++) begin
            if (ent_i[k].wsel[b]) begin
              fwd_data[8*b +: 8] = ent_i[k].data[8*b +: 8];
              fwd_mask[b]        = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: multi-lane store buffer with in-order drain and load forwarding.
// Optional LL/SC reservation bit enabled by defining MEM_LLSC_EN; SC rides on lane 0.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             st_valid,
  input  logic [LANES-1:0][ADDR_W-1:0] st_addr,
  input  logic [LANES-1:0][31:0]       st_wdata,
  input  logic [LANES-1:0][3:0]        st_wsel,
  output logic                         st_ready,
  input  logic                         ld_valid,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic [31:0]                  ld_fwd_data,
  output logic [3:0]                   ld_fwd_mask,
  mem_store_buffer_if.master           mem,
  input  logic                         ll_valid,
  input  logic                         sc_valid,
  input  logic                         llbit_clr,
  output logic                         sc_success,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d, n_acc;
  logic [LANES-1:0]      acc;
  logic                  pop;
  sb_entry_t             head_e;
  sb_entry_t [DEPTH-1:0] ord;
  logic [DEPTH-1:0]      ord_vld;
  logic                  unused_lo;

  assign st_ready = (DEPTH_C - count_q) >= LANES_C;
  assign empty    = (count_q == '0);
  assign pop      = mem.mem_req & mem.mem_ack;

  assign head_e        = entries_q[head_q];
  assign mem.mem_req   = !empty;
  assign mem.mem_addr  = {head_e.waddr[ADDR_W-3:0], 2'b00};
  assign mem.mem_wdata = head_e.data;
  assign mem.mem_wsel  = head_e.wsel;

  // Lane acceptance: needs room, a non-empty byte select, and a live reservation for SC.
  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      acc[i] = st_valid[i] & st_ready & (st_wsel[i] != SB_WSEL_NONE);
    end
    if (sc_valid && !sc_success) acc[0] = 1'b0;
  end

  // Enqueue accepted lanes in lane order at the tail; pointers wrap naturally.
  always_comb begin
    entries_d = entries_q;
    tail_d    = tail_q;
    n_acc     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (acc[i]) begin
        entries_d[tail_d].waddr = SB_WADDR_W'(st_addr[i][ADDR_W-1:2]);
        entries_d[tail_d].data  = st_wdata[i];
        entries_d[tail_d].wsel  = st_wsel[i];
        tail_d = tail_d + PTR_W'(1);
        n_acc  = n_acc + CNT_W'(1);
      end
    end
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + n_acc - CNT_W'(pop);
  end

  // Buffer bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Present registered entries oldest-first; same-cycle stores are not yet visible.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord[k]     = entries_q[head_q + PTR_W'(k)];
      ord_vld[k] = (CNT_W'(k) < count_q);
    end
  end

  sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd (
    .ent_i    (ord),
    .vld_i    (ord_vld),
    .ld_valid (ld_valid),
    .ld_waddr (SB_WADDR_W'(ld_addr[ADDR_W-1:2])),
    .fwd_data (ld_fwd_data),
    .fwd_mask (ld_fwd_mask)
  );

  // Byte-offset address bits are irrelevant to word-granular buffering.
  always_comb begin
    unused_lo = ^ld_addr[1:0];
    for (int i = 0; i < LANES; i++) unused_lo = unused_lo ^ (^st_addr[i][1:0]);
  end

`ifdef MEM_LLSC_EN
  logic llbit_q, llbit_d;

  // Reservation bit: set by LL, consumed by a successful SC, clear has priority.
  always_comb begin
    llbit_d = llbit_q;
    if (ll_valid)            llbit_d = 1'b1;
    if (sc_valid && acc[0])  llbit_d = 1'b0;
    if (llbit_clr)           llbit_d = 1'b0;
  end

  // Reservation register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) llbit_q <= 1'b0;
    else     llbit_q <= llbit_d;
  end

  assign sc_success = llbit_q;
`else
  logic unused_llsc;
  assign unused_llsc = ll_valid ^ llbit_clr;
  assign sc_success  = 1'b1;
`endif

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer (LANES=2, DEPTH=4, ADDR_W=32).
module tb_mem_store_buffer;
  localparam int LANES  = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [LANES-1:0]             st_valid;
  logic [LANES-1:0][ADDR_W-1:0] st_addr;
  logic [LANES-1:0][31:0]       st_wdata;
  logic [LANES-1:0][3:0]        st_wsel;
  logic                         st_ready;
  logic                         ld_valid;
  logic [ADDR_W-1:0]            ld_addr;
  logic [31:0]                  ld_fwd_data;
  logic [3:0]                   ld_fwd_mask;
  logic                         ll_valid, sc_valid, llbit_clr, sc_success, empty;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_store_buffer_if #(.ADDR_W(ADDR_W)) mem_bus ();

  mem_store_buffer #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_wdata    (st_wdata),
    .st_wsel     (st_wsel),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_fwd_data (ld_fwd_data),
    .ld_fwd_mask (ld_fwd_mask),
    .mem         (mem_bus),
    .ll_valid    (ll_valid),
    .sc_valid    (sc_valid),
    .llbit_clr   (llbit_clr),
    .sc_success  (sc_success),
    .empty       (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_st();
    st_valid = '0;
    st_addr  = '0;
    st_wdata = '0;
    st_wsel  = '0;
  endtask

  task automatic put(input int lane, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] w);
    st_valid[lane] = 1'b1;
    st_addr[lane]  = a;
    st_wdata[lane] = d;
    st_wsel[lane]  = w;
  endtask

  initial begin
    rst = 1'b1;
    clr_st();
    ld_valid = 1'b0;
    ld_addr = '0;
    ll_valid = 1'b0;
    sc_valid = 1'b0;
    llbit_clr = 1'b0;
    mem_bus.mem_ack = 1'b0;
    #3;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_mem_req", mem_bus.mem_req, 0);
    chk("rst_count", dut.count_q, 0);
`ifdef MEM_LLSC_EN
    chk("rst_sc_success", sc_success, 0);
`else
    chk("rst_sc_success", sc_success, 1);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single full-word store, forwarded to an unaligned load in the same word
    put(0, 32'h100, 32'h1122_3344, 4'b1111);
    tick();
    clr_st();
    ld_valid = 1'b1;
    ld_addr = 32'h102;
    settle();
    chk("a_mem_req", mem_bus.mem_req, 1);
    chk("a_mem_addr", mem_bus.mem_addr, 32'h100);
    chk("a_mem_wsel", mem_bus.mem_wsel, 4'hF);
    chk("a_count", dut.count_q, 1);
    chk("a_fwd_mask", ld_fwd_mask, 4'hF);
    chk("a_fwd_data", ld_fwd_data, 32'h1122_3344);
    ld_valid = 1'b0;
    settle();
    chk("a_mask_ld_off", ld_fwd_mask, 0);
    chk("a_data_ld_off", ld_fwd_data, 0);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    settle();
    chk("a_empty", empty, 1);

    // youngest byte wins; zero-wsel store allocates nothing
    put(0, 32'h200, 32'h0000_00AA, 4'b0001);
    tick();
    put(0, 32'h200, 32'h0000_00BB, 4'b0001);
    tick();
    put(0, 32'h200, 32'hFFFF_FFFF, 4'b0000);
    tick();
    clr_st();
    ld_valid = 1'b1;
    ld_addr = 32'h200;
    settle();
    chk("b_mask", ld_fwd_mask, 4'b0001);
    chk("b_data", ld_fwd_data, 32'h0000_00BB);
    chk("b_count_wsel0", dut.count_q, 2);
    chk("b_head_wdata", mem_bus.mem_wdata, 32'h0000_00AA);
    ld_addr = 32'h204;
    settle();
    chk("b_mask_miss", ld_fwd_mask, 0);
    ld_valid = 1'b0;
    mem_bus.mem_ack = 1'b1;
    tick();
    chk("b_wdata_second", mem_bus.mem_wdata, 32'h0000_00BB);
    tick();
    mem_bus.mem_ack = 1'b0;
    settle();
    chk("b_empty", empty, 1);

    // two lanes in one cycle: lane order drain, no same-cycle forwarding
    put(0, 32'h300, 32'h3030_3030, 4'b1111);
    put(1, 32'h304, 32'h3434_3434, 4'b1111);
    ld_valid = 1'b1;
    ld_addr = 32'h300;
    settle();
    chk("c_same_cycle_mask", ld_fwd_mask, 0);
    tick();
    clr_st();
    settle();
    chk("c_mask_next_cycle", ld_fwd_mask, 4'hF);
    chk("c_count", dut.count_q, 2);
    chk("c_addr_first", mem_bus.mem_addr, 32'h300);
    mem_bus.mem_ack = 1'b1;
    tick();
    chk("c_addr_second", mem_bus.mem_addr, 32'h304);
    ld_addr = 32'h304;
    settle();
    chk("c_ack_cycle_mask", ld_fwd_mask, 4'hF);
    chk("c_ack_cycle_data", ld_fwd_data, 32'h3434_3434);
    tick();
    mem_bus.mem_ack = 1'b0;
    ld_valid = 1'b0;
    settle();
    chk("c_empty", empty, 1);

    // fill to DEPTH, st_ready only returns once two slots are free
    put(0, 32'h500, 32'hA0A0_A0A0, 4'b1111);
    put(1, 32'h504, 32'hA1A1_A1A1, 4'b1111);
    tick();
    settle();
    chk("d_count2", dut.count_q, 2);
    chk("d_ready2", st_ready, 1);
    put(0, 32'h508, 32'hA2A2_A2A2, 4'b1111);
    put(1, 32'h50C, 32'hA3A3_A3A3, 4'b1111);
    tick();
    clr_st();
    settle();
    chk("d_count4", dut.count_q, 4);
    chk("d_ready_full", st_ready, 0);
    mem_bus.mem_ack = 1'b1;
    settle();
    chk("d_ready_pop_cycle", st_ready, 0);
    tick();
    mem_bus.mem_ack = 1'b0;
    put(0, 32'h510, 32'hDEAD_BEEF, 4'b1111);
    settle();
    chk("d_count3", dut.count_q, 3);
    chk("d_ready_free1", st_ready, 0);
    tick();
    clr_st();
    settle();
    chk("d_refused", dut.count_q, 3);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    settle();
    chk("d_ready_free2", st_ready, 1);
    chk("d_count2_after", dut.count_q, 2);
    chk("d_head_addr", mem_bus.mem_addr, 32'h508);
    ld_valid = 1'b1;
    ld_addr = 32'h50C;
    settle();
    chk("d_wrap_mask", ld_fwd_mask, 4'hF);
    chk("d_wrap_data", ld_fwd_data, 32'hA3A3_A3A3);
    ld_valid = 1'b0;
    mem_bus.mem_ack = 1'b1;
    tick();
    tick();
    mem_bus.mem_ack = 1'b0;
    settle();
    chk("d_empty", empty, 1);

`ifdef MEM_LLSC_EN
    // reservation set, cleared, then SC must fail; set again and SC succeeds
    ll_valid = 1'b1;
    tick();
    ll_valid = 1'b0;
    settle();
    chk("e_ll_set", sc_success, 1);
    llbit_clr = 1'b1;
    tick();
    llbit_clr = 1'b0;
    settle();
    chk("e_ll_cleared", sc_success, 0);
    sc_valid = 1'b1;
    put(0, 32'h400, 32'h4444_4444, 4'b1111);
    tick();
    clr_st();
    sc_valid = 1'b0;
    settle();
    chk("e_sc_fail_count", dut.count_q, 0);
    chk("e_sc_fail_empty", empty, 1);
    ll_valid = 1'b1;
    llbit_clr = 1'b1;
    tick();
    ll_valid = 1'b0;
    llbit_clr = 1'b0;
    settle();
    chk("e_clear_wins", sc_success, 0);
    ll_valid = 1'b1;
    tick();
    ll_valid = 1'b0;
    settle();
    chk("e_ll_set_again", sc_success, 1);
    sc_valid = 1'b1;
    put(0, 32'h400, 32'h4444_4444, 4'b1111);
    tick();
    clr_st();
    sc_valid = 1'b0;
    settle();
    chk("e_sc_ok_count", dut.count_q, 1);
    chk("e_sc_ok_addr", mem_bus.mem_addr, 32'h400);
    chk("e_sc_consumed", sc_success, 0);
`else
    // without the reservation feature SC is an ordinary store
    ll_valid = 1'b1;
    tick();
    ll_valid = 1'b0;
    llbit_clr = 1'b1;
    tick();
    llbit_clr = 1'b0;
    settle();
    chk("e_sc_tied", sc_success, 1);
    sc_valid = 1'b1;
    put(0, 32'h400, 32'h4444_4444, 4'b1111);
    tick();
    clr_st();
    sc_valid = 1'b0;
    settle();
    chk("e_sc_plain_count", dut.count_q, 1);
    chk("e_sc_plain_addr", mem_bus.mem_addr, 32'h400);
`endif
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    settle();
    chk("e_empty", empty, 1);

    // asynchronous reset in the middle of a drain
    put(0, 32'h600, 32'h6060_6060, 4'b1111);
    put(1, 32'h604, 32'h6464_6464, 4'b1111);
    tick();
    clr_st();
    put(0, 32'h608, 32'h6868_6868, 4'b1111);
    tick();
    clr_st();
    settle();
    chk("f_count3", dut.count_q, 3);
    chk("f_req_before", mem_bus.mem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("f_req_async", mem_bus.mem_req, 0);
    chk("f_empty_async", empty, 1);
    chk("f_ready_async", st_ready, 1);
    chk("f_count_async", dut.count_q, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_store_buffer.md
MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 SHALL have parameter LANES, default 2: store lanes accepted per cycle; lane 0 is older than lane 1.
REQ-002 SHALL have parameter DEPTH, default 4: number of buffer entries; power of two, at least LANES.
REQ-003 SHALL have parameter ADDR_W, default 32: byte address width; data width is fixed at 32 with 4 byte enables.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports st_valid[LANES], st_addr[LANES][ADDR_W], st_wdata[LANES][32] and st_wsel[LANES][4], all inputs: already-aligned store requests in memory-stage form.
REQ-007 SHALL have port st_ready, output, 1 bit: high iff free entries >= LANES.
REQ-008 SHALL have ports ld_valid, input, 1 bit, and ld_addr, input, ADDR_W bits: load forwarding probe.
REQ-009 SHALL have ports ld_fwd_data, output, 32 bits, and ld_fwd_mask, output, 4 bits: forwarded bytes and their byte mask.
REQ-010 SHALL have ports mem_req, output, 1 bit; mem_addr, output, ADDR_W bits; mem_wdata, output, 32 bits; mem_wsel, output, 4 bits; and mem_ack, input, 1 bit: drain interface to the data SRAM.
REQ-011 SHALL have ports ll_valid, sc_valid and llbit_clr, inputs, 1 bit each, and sc_success, output, 1 bit: LL/SC support.
REQ-012 SHALL have port empty, output, 1 bit: high when no entry is buffered.

Function
REQ-013 SHALL accept a lane's store when st_valid[i] and st_ready are both high in the same cycle.
REQ-014 SHALL enqueue same-cycle stores in lane order at the tail, wrapping at DEPTH.
REQ-015 SHALL ignore any store with st_wsel equal to 0, allocating no entry for it.
REQ-016 SHALL compute st_ready only from the registered count, so a same-cycle pop does not raise st_ready.
REQ-017 SHALL drive mem_req high whenever count > 0, with mem_addr, mem_wdata and mem_wsel taken from the head entry.
REQ-018 SHALL hold the head entry stable until mem_ack is seen.
REQ-019 SHALL pop the head on mem_req & mem_ack, with the next entry presented in the following cycle.
REQ-020 SHALL update count on simultaneous enqueue and pop as count + accepted - popped.
REQ-021 SHALL never let count exceed DEPTH or fall below 0.
REQ-022 SHALL compute forwarding combinationally: a buffered entry matches ld_addr when addr[ADDR_W-1:2] are equal.
REQ-023 SHALL take each forwarded byte from the youngest matching entry whose wsel bit is set.
REQ-024 SHALL exclude stores enqueued in the same cycle from forwarding.
REQ-025 SHALL drive ld_fwd_mask as the OR of the wsel bits of matching entries, and 0 when ld_valid is low.
REQ-026 SHALL drive ld_fwd_data bytes to 0 wherever the mask bit is 0.
REQ-027 SHALL keep the entry being acked forwardable during its ack cycle.

Reset
REQ-028 SHALL, on rst, asynchronously clear head, tail, count, mem_req and the LL bit to 0, leaving st_ready = 1 and empty = 1.
REQ-029 SHALL, on rst mid-drain, drop the outstanding request; the SRAM side tolerates mem_req falling without an ack.
REQ-030 SHALL not reset entry payload contents.

Configuration
REQ-031 SHALL, with MEM_LLSC_EN defined, set the LL bit on ll_valid and clear it on llbit_clr, with clear winning over set.
REQ-032 SHALL, with MEM_LLSC_EN defined, drive sc_success equal to the LL bit and accept an SC lane store only when sc_success is 1; on success the LL bit is cleared.
REQ-033 SHALL, with MEM_LLSC_EN undefined, tie sc_success to 1, treat SC as a plain store, and synthesise no LL bit register.

Structure
REQ-034 SHALL place the sb_entry_t struct {word address, data, wsel} and the byte-lane mask constants in shared package mem_pkg.
REQ-035 SHALL implement per-byte youngest-match priority selection in one sub-module, sb_fwd_merge.

Verification
REQ-036 SHALL check: after reset, store 0x11223344 to 0x100 with wsel 1111 on lane 0, no ack -> mem_req = 1, mem_addr = 0x100, count = 1, and a load at 0x102 gives mask 1111 and data 0x11223344.
REQ-037 SHALL check: store wsel 0001 of data 0xAA, then wsel 0001 of data 0xBB, both at 0x200, then a load at 0x200 -> mask 0001, data 0x000000BB.
REQ-038 SHALL check: DEPTH = 4, LANES = 2, fill 4 entries with no ack -> st_ready = 0; ack one -> st_ready still 0 (free = 1); ack one more -> st_ready = 1 next cycle.
REQ-039 SHALL check: with both lanes valid, lane 0 at 0x300 and lane 1 at 0x304 -> drained in order 0x300 then 0x304 over two acks, and a same-cycle load at 0x300 gives mask 0.
REQ-040 SHALL check, with MEM_LLSC_EN defined: ll_valid, then llbit_clr, then SC to 0x400 -> sc_success = 0 and no entry added; ll_valid then SC -> sc_success = 1 and the entry is added.
REQ-041 SHALL check: rst asserted with 3 entries and mem_req high -> mem_req = 0 and empty = 1 immediately, without waiting for a clock.
